id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
Pipeline register between decode and execute.
- Captures decoded instruction fields plus the two operands read asynchronously from the decode-stage register file.
- Applies a writeback-to-decode bypass, so a register written in the same cycle it is read yields the new value. The register file itself returns the old value in that case.
- Detects load-use hazards, inserts bubbles, honours execute stalls and branch flushes, and counts hazard bubbles for performance monitoring.

Parameters:
CTRL_W, 16, width of opaque execute control bundle passed through unchanged
CNT_W, 16, width of saturating bubble counter

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  decode holds a real instruction
in_pc  input  32  instruction PC
in_rs1  input  5  source register 1 index
in_rs2  input  5  source register 2 index
in_rd  input  5  destination register index
in_rs1_data  input  32  register file read_data1
in_rs2_data  input  32  register file read_data2
in_imm  input  32  sign-extended immediate
in_ctrl  input  CTRL_W  execute control bundle
in_mem_read  input  1  instruction is a load
in_reg_write  input  1  instruction writes rd
wb_wEn  input  1  writeback write enable (same signal driving register file wEn)
wb_write_sel  input  5  writeback destination index
wb_write_data  input  32  writeback data
ex_stall  input  1  execute cannot accept; hold contents
flush  input  1  kill incoming instruction (branch/jump taken)
out_valid  output  1  execute holds a real instruction
out_pc  output  32  registered PC
out_rs1  output  5  registered rs1
out_rs2  output  5  registered rs2
out_rd  output  5  registered rd
out_rs1_data  output  32  registered operand 1
out_rs2_data  output  32  registered operand 2
out_imm  output  32  registered immediate
out_ctrl  output  CTRL_W  registered control
out_mem_read  output  1  registered load flag
out_reg_write  output  1  registered write flag
hazard_stall  output  1  load-use hazard; decode and fetch must hold
bubble_count  output  CNT_W  number of hazard bubbles inserted

Behaviour:
- All outputs are registered except hazard_stall, which is combinational. Latency from decode to execute is 1 cycle.
- Reset: all registered outputs go to 0, including out_valid and bubble_count.
- Bypass, applied to the captured operands:
  - bypass1 = wb_wEn & (wb_write_sel != 0) & (wb_write_sel == in_rs1); when true, the captured operand 1 is wb_write_data, otherwise in_rs1_data.
  - The same rule applies to rs2 independently.
  - Index x0 is never bypassed.
- hazard = out_valid & out_mem_read & out_reg_write & (out_rd != 0) & in_valid & ((in_rs1 == out_rd) | (in_rs2 == out_rd)).
- hazard_stall = hazard & ~flush & ~ex_stall.
- Per-cycle update, in priority order (first matching case wins):
  1. reset: clear as above.
  2. flush: out_valid <= 0 and out_mem_read <= 0, out_reg_write <= 0. Other fields are don't-care and may load. bubble_count is unchanged. Flush overrides ex_stall.
  3. ex_stall: hold all fields.
     - If out_valid and wb_wEn and wb_write_sel != 0, refresh held data: out_rs1_data <= wb_write_data when wb_write_sel == out_rs1; same rule for rs2.
     - This keeps a held instruction coherent with writebacks that retire during the stall.
  4. hazard: insert bubble.
     - out_valid, out_mem_read and out_reg_write <= 0.
     - bubble_count <= bubble_count + 1, saturating at all-ones.
     - The load in execute advances (owned by the downstream stage).
     - The decode instruction is re-presented next cycle by the held upstream stage.
  5. otherwise: load all in_* fields, with bypassed operands. out_valid <= in_valid.
- When in_valid = 0 on a normal load, out_valid <= 0 and out_mem_read/out_reg_write <= 0. This prevents false hazards from garbage.
- A hazard lasts exactly one cycle per load, because the bubble clears out_valid. A back-to-back dependent load pair therefore yields one bubble per load.
- Reset asserted while stalled or in the middle of a hazard wins unconditionally. hazard_stall is 0 in the cycle after reset.
- bubble_count saturates; it never wraps to 0.

Test Plan:
1. Reset asserted for 2 cycles with garbage inputs -> all outputs 0, hazard_stall = 0, bubble_count = 0.
2. in_valid = 1, rs1 = 5, in_rs1_data = 0x11, wb_wEn = 1, wb_write_sel = 5, wb_write_data = 0xAA -> next cycle out_rs1_data = 0xAA.
   Repeat with wb_write_sel = 0, in_rs1 = 0, in_rs1_data = 0 -> out_rs1_data = 0.
3. Load (out_mem_read = 1, out_rd = 7) in execute; decode presents rs2 = 7 -> hazard_stall = 1 that cycle. Next cycle out_valid = 0 and bubble_count = 1; the instruction re-presented with the load gone is then captured normally.
4. Hold ex_stall = 1 for 3 cycles with out_rs2 = 3; wb writes x3 = 0x55 during the hold -> outputs frozen except out_rs2_data = 0x55. hazard_stall = 0 throughout.
5. flush = 1 together with ex_stall = 1 and a pending hazard -> next cycle out_valid = 0, bubble_count unchanged, hazard_stall = 0 during the flush cycle.
6. Force bubble_count = 0xFFFE via 0xFFFE hazards (or force), then 3 more hazards -> bubble_count = 0xFFFF and stays there.

Source files
------------

// File: rtl/id_ex_stage.sv
// ============================================================================
// id_ex_stage
// ----------------------------------------------------------------------------
// Purpose:
//   Pipeline register between decode and execute. It captures the decoded
//   instruction fields and the two register-file operands. A writeback in
//   the same cycle as the read is bypassed into the captured operands.
//   The stage also detects load-use hazards, inserts bubbles, holds on
//   execute stalls, kills on branch flushes, and counts hazard bubbles.
//
// Ports:
//   clock, reset           rising-edge clock, synchronous active-high reset
//   in_*                   decode-stage instruction fields and operands
//   wb_wEn/wb_write_sel/
//   wb_write_data          writeback port (same signals drive the regfile)
//   ex_stall               execute cannot accept; hold contents
//   flush                  kill the incoming instruction (taken branch/jump)
//   out_*                  registered execute-stage instruction fields
//   hazard_stall           combinational load-use hazard; fetch/decode hold
//   bubble_count           saturating count of inserted hazard bubbles
//
// Flow-control contract:
//   in_valid marks a real decode instruction. It is accepted on a clock
//   edge when flush, ex_stall and hazard_stall are all low. flush drops it.
//   ex_stall and hazard_stall both make the upstream stage hold and
//   re-present the same instruction. out_valid marks a real instruction in
//   execute. While ex_stall is high, the execute-side contents stay fixed,
//   except that operands are refreshed by retiring writebacks.
// ============================================================================
module id_ex_stage #(
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [31:0]       in_pc,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic [31:0]       in_rs1_data,
    input  logic [31:0]       in_rs2_data,
    input  logic [31:0]       in_imm,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              in_mem_read,
    input  logic              in_reg_write,
    input  logic              wb_wEn,
    input  logic [4:0]        wb_write_sel,
    input  logic [31:0]       wb_write_data,
    input  logic              ex_stall,
    input  logic              flush,
    output logic              out_valid,
    output logic [31:0]       out_pc,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic [4:0]        out_rd,
    output logic [31:0]       out_rs1_data,
    output logic [31:0]       out_rs2_data,
    output logic [31:0]       out_imm,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              out_mem_read,
    output logic              out_reg_write,
    output logic              hazard_stall,
    output logic [CNT_W-1:0]  bubble_count
);

    logic              valid_q,     valid_d;
    logic [31:0]       pc_q,        pc_d;
    logic [4:0]        rs1_q,       rs1_d;
    logic [4:0]        rs2_q,       rs2_d;
    logic [4:0]        rd_q,        rd_d;
    logic [31:0]       rs1_data_q,  rs1_data_d;
    logic [31:0]       rs2_data_q,  rs2_data_d;
    logic [31:0]       imm_q,       imm_d;
    logic [CTRL_W-1:0] ctrl_q,      ctrl_d;
    logic              mem_read_q,  mem_read_d;
    logic              reg_write_q, reg_write_d;
    logic [CNT_W-1:0]  bubble_q,    bubble_d;

    // The register file returns stale data when it is written and read in
    // the same cycle, so the writeback value is forwarded here. x0 is
    // hard-wired to zero and is never forwarded.
    logic        wb_live;
    logic        byp1;
    logic        byp2;
    logic [31:0] op1;
    logic [31:0] op2;

    assign wb_live = wb_wEn & (wb_write_sel != 5'd0);
    assign byp1    = wb_live & (wb_write_sel == in_rs1);
    assign byp2    = wb_live & (wb_write_sel == in_rs2);
    assign op1     = byp1 ? wb_write_data : in_rs1_data;
    assign op2     = byp2 ? wb_write_data : in_rs2_data;

    // A load in execute whose rd feeds the decode instruction. Its data
    // is not available until after execute, so one bubble is required.
    logic hazard;

    assign hazard = valid_q & mem_read_q & reg_write_q & (rd_q != 5'd0) &
                    in_valid & ((in_rs1 == rd_q) | (in_rs2 == rd_q));

    // Flush and execute stall already stop decode from advancing, so in
    // those cases the hazard does not need to be reported upstream.
    assign hazard_stall = hazard & ~flush & ~ex_stall;

    always_comb begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        imm_d       = imm_q;
        ctrl_d      = ctrl_q;
        mem_read_d  = mem_read_q;
        reg_write_d = reg_write_q;
        bubble_d    = bubble_q;

        if (flush) begin
            // The payload may load freely. Only the validity and
            // side-effect flags must be cleared.
            pc_d        = in_pc;
            rs1_d       = in_rs1;
            rs2_d       = in_rs2;
            rd_d        = in_rd;
            rs1_data_d  = op1;
            rs2_data_d  = op2;
            imm_d       = in_imm;
            ctrl_d      = in_ctrl;
            valid_d     = 1'b0;
            mem_read_d  = 1'b0;
            reg_write_d = 1'b0;
        end else if (ex_stall) begin
            // A held instruction must observe writebacks that retire
            // while it waits, or it would execute with stale operands.
            if (valid_q && wb_live) begin
                if (wb_write_sel == rs1_q) begin
                    rs1_data_d = wb_write_data;
                end
                if (wb_write_sel == rs2_q) begin
                    rs2_data_d = wb_write_data;
                end
            end
        end else if (hazard) begin
            valid_d     = 1'b0;
            mem_read_d  = 1'b0;
            reg_write_d = 1'b0;
            if (bubble_q != {CNT_W{1'b1}}) begin
                bubble_d = bubble_q + CNT_W'(1);
            end
        end else begin
            pc_d        = in_pc;
            rs1_d       = in_rs1;
            rs2_d       = in_rs2;
            rd_d        = in_rd;
            rs1_data_d  = op1;
            rs2_data_d  = op2;
            imm_d       = in_imm;
            ctrl_d      = in_ctrl;
            valid_d     = in_valid;
            // Gating with in_valid prevents a false hazard caused by
            // garbage flags on an empty decode slot.
            mem_read_d  = in_valid & in_mem_read;
            reg_write_d = in_valid & in_reg_write;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            ctrl_q      <= '0;
            mem_read_q  <= 1'b0;
            reg_write_q <= 1'b0;
            bubble_q    <= '0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            ctrl_q      <= ctrl_d;
            mem_read_q  <= mem_read_d;
            reg_write_q <= reg_write_d;
            bubble_q    <= bubble_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_pc        = pc_q;
    assign out_rs1       = rs1_q;
    assign out_rs2       = rs2_q;
    assign out_rd        = rd_q;
    assign out_rs1_data  = rs1_data_q;
    assign out_rs2_data  = rs2_data_q;
    assign out_imm       = imm_q;
    assign out_ctrl      = ctrl_q;
    assign out_mem_read  = mem_read_q;
    assign out_reg_write = reg_write_q;
    assign bubble_count  = bubble_q;

endmodule
